// File: rtl/rtimer_commander_p.sv
// Button-driven BCD timer (min:sec:centisec) with a built-in 10 ms tick
// prescaler. It counts down to zero or up to MIN_MAX:59.99, can pause, and
// can optionally reload itself on timeout. The user-set preset is kept
// separate from the running value, so a finished or aborted run always
// returns to the last edited time.
module rtimer_commander_p #(
    parameter int          TICK_DIV    = 500000,
    parameter int          COUNT_UP    = 0,
    parameter int          AUTO_RELOAD = 0,
    parameter logic [7:0]  MIN_MAX     = 8'h99,
    parameter logic [7:0]  DEFAULT_MIN = 8'h05,
    parameter logic [7:0]  DEFAULT_SEC = 8'h00
) (
    input  logic       clk_core,
    input  logic       rst_n,
    input  logic       center_button,
    input  logic       left_button,
    input  logic       right_button,
    input  logic       up_button,
    input  logic       down_button,
    output logic [7:0] min_o,
    output logic [7:0] sec_o,
    output logic [7:0] ms_10_o,
    output logic [1:0] target,
    output logic       time_out_o,
    output logic [1:0] state_o
);

    localparam int          PW         = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [23:0] RESET_VAL  = {DEFAULT_MIN, DEFAULT_SEC, 8'h00};
    // Value whose arrival ends a run: zero counting down, the top counting up.
    localparam logic [23:0] TERM_VAL   = (COUNT_UP != 0) ? {MIN_MAX, 8'h59, 8'h99} : 24'h0;

    typedef enum logic [1:0] {
        ST_EDIT  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

    state_t        state;
    logic [23:0]   preset;
    logic [23:0]   run_val;
    logic [23:0]   disp;
    logic [PW-1:0] presc;

    logic [3:0]    dir_btn;
    logic          single;
    logic          press_left;
    logic          press_right;
    logic          press_up;
    logic          press_down;
    logic [23:0]   preset_up;
    logic [23:0]   preset_dn;
    logic [23:0]   step_val;
    logic [23:0]   base_val;

    // BCD increment of one byte field, wrapping past max back to 00.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
        logic [7:0] r;
        if (v >= max)
            r = 8'h00;
        else if (v[3:0] == 4'h9)
            r = {v[7:4] + 4'd1, 4'h0};
        else
            r = v + 8'd1;
        return r;
    endfunction

    // BCD decrement of one byte field, wrapping below 00 back to max.
    function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] max);
        logic [7:0] r;
        if (v == 8'h00)
            r = max;
        else if (v[3:0] == 4'h0)
            r = {v[7:4] - 4'd1, 4'h9};
        else
            r = v - 8'd1;
        return r;
    endfunction

    // One centisecond down with borrow cs -> sec -> min.
    function automatic logic [23:0] step_down(input logic [23:0] v);
        logic [7:0] m;
        logic [7:0] s;
        logic [7:0] c;
        m = v[23:16];
        s = v[15:8];
        c = v[7:0];
        if (c != 8'h00) begin
            c = bcd_dec(c, 8'h99);
        end else begin
            c = 8'h99;
            if (s != 8'h00) begin
                s = bcd_dec(s, 8'h59);
            end else begin
                s = 8'h59;
                m = bcd_dec(m, MIN_MAX);
            end
        end
        return {m, s, c};
    endfunction

    // One centisecond up with carry cs -> sec -> min.
    function automatic logic [23:0] step_up(input logic [23:0] v);
        logic [7:0] m;
        logic [7:0] s;
        logic [7:0] c;
        m = v[23:16];
        s = v[15:8];
        c = v[7:0];
        if (c != 8'h99) begin
            c = bcd_inc(c, 8'h99);
        end else begin
            c = 8'h00;
            if (s != 8'h59) begin
                s = bcd_inc(s, 8'h59);
            end else begin
                s = 8'h00;
                m = bcd_inc(m, MIN_MAX);
            end
        end
        return {m, s, c};
    endfunction

    // Center wins outright; the other buttons act only when exactly one is pressed.
    assign dir_btn     = {left_button, right_button, up_button, down_button};
    assign single      = !center_button && (dir_btn != 4'd0) && ((dir_btn & (dir_btn - 4'd1)) == 4'd0);
    assign press_left  = single && left_button;
    assign press_right = single && right_button;
    assign press_up    = single && up_button;
    assign press_down  = single && down_button;

    assign step_val = (COUNT_UP != 0) ? step_up(run_val) : step_down(run_val);
    // Starting value of a run and reload value after an auto-reload timeout.
    assign base_val = (COUNT_UP != 0) ? 24'h0 : preset;

    assign min_o   = disp[23:16];
    assign sec_o   = disp[15:8];
    assign ms_10_o = disp[7:0];
    assign state_o = state;

    // Preset candidates after an up/down press on the selected field.
    always_comb begin
        preset_up = preset;
        preset_dn = preset;
        case (target)
            2'b00: begin
                preset_up[7:0] = bcd_inc(preset[7:0], 8'h99);
                preset_dn[7:0] = bcd_dec(preset[7:0], 8'h99);
            end
            2'b01: begin
                preset_up[15:8] = bcd_inc(preset[15:8], 8'h59);
                preset_dn[15:8] = bcd_dec(preset[15:8], 8'h59);
            end
            2'b10: begin
                preset_up[23:16] = bcd_inc(preset[23:16], MIN_MAX);
                preset_dn[23:16] = bcd_dec(preset[23:16], MIN_MAX);
            end
            default: ;
        endcase
    end

    // Timer FSM: edit, run, pause and done, with all outputs registered.
    always_ff @(posedge clk_core or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_EDIT;
            target     <= 2'b01;
            time_out_o <= 1'b0;
            preset     <= RESET_VAL;
            run_val    <= RESET_VAL;
            disp       <= RESET_VAL;
            presc      <= '0;
        end else begin
            case (state)
                ST_EDIT: begin
                    if (center_button) begin
                        // A zero preset has nothing to count down from.
                        if (!(COUNT_UP == 0 && preset == 24'h0)) begin
                            state   <= ST_RUN;
                            target  <= 2'b11;
                            presc   <= '0;
                            run_val <= base_val;
                            disp    <= base_val;
                        end
                    end else if (press_left) begin
                        if (target != 2'b10)
                            target <= target + 2'b01;
                    end else if (press_right) begin
                        if (target != 2'b00)
                            target <= target - 2'b01;
                    end else if (press_up) begin
                        preset <= preset_up;
                        disp   <= preset_up;
                    end else if (press_down) begin
                        preset <= preset_dn;
                        disp   <= preset_dn;
                    end
                end
                ST_RUN: begin
                    time_out_o <= 1'b0;
                    if (center_button) begin
                        state <= ST_PAUSE;
                    end else if (presc == PRESC_LAST) begin
                        presc <= '0;
                        if (step_val == TERM_VAL) begin
                            time_out_o <= 1'b1;
                            if (AUTO_RELOAD != 0) begin
                                run_val <= base_val;
                                disp    <= base_val;
                            end else begin
                                run_val <= step_val;
                                disp    <= step_val;
                                state   <= ST_DONE;
                            end
                        end else begin
                            run_val <= step_val;
                            disp    <= step_val;
                        end
                    end else begin
                        presc <= presc + 1'b1;
                    end
                end
                ST_PAUSE: begin
                    if (center_button) begin
                        state <= ST_RUN;
                    end else if (press_right) begin
                        run_val <= preset;
                        disp    <= preset;
                        state   <= ST_EDIT;
                        target  <= 2'b01;
                    end
                end
                ST_DONE: begin
                    if (center_button) begin
                        time_out_o <= 1'b0;
                        state      <= ST_EDIT;
                        target     <= 2'b01;
                        disp       <= preset;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rtimer_commander_p.sv
// Bench for rtimer_commander_p: three instances (plain count-down,
// auto-reload, count-up with MIN_MAX=00) share clock, reset and buttons;
// each scenario starts from reset and checks only the instance it targets.
module tb_rtimer_commander_p;

    logic clk_core = 1'b0;
    logic rst_n;
    logic center_button, left_button, right_button, up_button, down_button;

    logic [7:0] d_min, d_sec, d_cs;
    logic [1:0] d_tgt, d_st;
    logic       d_tmo;
    logic [7:0] r_min, r_sec, r_cs;
    logic [1:0] r_tgt, r_st;
    logic       r_tmo;
    logic [7:0] u_min, u_sec, u_cs;
    logic [1:0] u_tgt, u_st;
    logic       u_tmo;

    always #5 clk_core = ~clk_core;

    rtimer_commander_p #(.TICK_DIV(4)) dut_d (
        .clk_core(clk_core), .rst_n(rst_n),
        .center_button(center_button), .left_button(left_button),
        .right_button(right_button), .up_button(up_button), .down_button(down_button),
        .min_o(d_min), .sec_o(d_sec), .ms_10_o(d_cs),
        .target(d_tgt), .time_out_o(d_tmo), .state_o(d_st)
    );

    rtimer_commander_p #(.TICK_DIV(4), .AUTO_RELOAD(1)) dut_r (
        .clk_core(clk_core), .rst_n(rst_n),
        .center_button(center_button), .left_button(left_button),
        .right_button(right_button), .up_button(up_button), .down_button(down_button),
        .min_o(r_min), .sec_o(r_sec), .ms_10_o(r_cs),
        .target(r_tgt), .time_out_o(r_tmo), .state_o(r_st)
    );

    rtimer_commander_p #(.TICK_DIV(4), .COUNT_UP(1), .MIN_MAX(8'h00), .DEFAULT_MIN(8'h00)) dut_u (
        .clk_core(clk_core), .rst_n(rst_n),
        .center_button(center_button), .left_button(left_button),
        .right_button(right_button), .up_button(up_button), .down_button(down_button),
        .min_o(u_min), .sec_o(u_sec), .ms_10_o(u_cs),
        .target(u_tgt), .time_out_o(u_tmo), .state_o(u_st)
    );

    typedef struct packed {
        logic [7:0] mn;
        logic [7:0] sc;
        logic [7:0] cs;
        logic [1:0] tgt;
        logic [1:0] st;
        logic       tmo;
    } obs_t;

    typedef struct {
        int    which;
        obs_t  v;
        string name;
    } exp_t;

    typedef struct {
        logic [4:0] btn;
        obs_t       v;
        string      name;
    } vec_t;

    // Button vector order: {center, left, right, up, down}
    localparam logic [4:0] B_N = 5'b00000;
    localparam logic [4:0] B_C = 5'b10000;
    localparam logic [4:0] B_L = 5'b01000;
    localparam logic [4:0] B_R = 5'b00100;
    localparam logic [4:0] B_U = 5'b00010;
    localparam logic [4:0] B_D = 5'b00001;

    exp_t sb[$];
    vec_t tbl[$];
    exp_t ce;
    int   total = 0;
    int   bad   = 0;

    function automatic obs_t ob(input logic [7:0] mn, input logic [7:0] sc, input logic [7:0] cs,
                                input logic [1:0] tgt, input logic [1:0] st, input logic tmo);
        obs_t o;
        o = {mn, sc, cs, tgt, st, tmo};
        return o;
    endfunction

    function automatic obs_t observe(input int which);
        obs_t o;
        case (which)
            1:       o = {r_min, r_sec, r_cs, r_tgt, r_st, r_tmo};
            2:       o = {u_min, u_sec, u_cs, u_tgt, u_st, u_tmo};
            default: o = {d_min, d_sec, d_cs, d_tgt, d_st, d_tmo};
        endcase
        return o;
    endfunction

    task automatic compare(input int which, input obs_t v, input string name);
        obs_t a;
        a = observe(which);
        total++;
        if (a !== v) begin
            bad++;
            $display("FAIL %s dut%0d: got %h:%h.%h tgt=%b st=%b to=%b, want %h:%h.%h tgt=%b st=%b to=%b",
                     name, which, a.mn, a.sc, a.cs, a.tgt, a.st, a.tmo,
                     v.mn, v.sc, v.cs, v.tgt, v.st, v.tmo);
        end
    endtask

    // Scoreboard consumer: each expectation is checked just after the edge that follows its stimulus.
    always begin
        @(posedge clk_core);
        #1;
        if (sb.size() > 0) begin
            ce = sb.pop_front();
            compare(ce.which, ce.v, ce.name);
        end
    end

    // Called at a falling edge: drive buttons for one cycle and queue the expected result.
    task automatic step(input logic [4:0] b, input int which, input obs_t v, input string name);
        exp_t e;
        {center_button, left_button, right_button, up_button, down_button} = b;
        e.which = which;
        e.v     = v;
        e.name  = name;
        sb.push_back(e);
        @(posedge clk_core);
        @(negedge clk_core);
        {center_button, left_button, right_button, up_button, down_button} = B_N;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk_core);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk_core);
        rst_n = 1'b1;
    endtask

    task automatic add(input logic [4:0] b, input obs_t v, input string name);
        vec_t t;
        t.btn  = b;
        t.v    = v;
        t.name = name;
        tbl.push_back(t);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        obs_t rst_d;
        rst_d = ob(8'h05, 8'h00, 8'h00, 2'b01, 2'b00, 1'b0);
        rst_n = 1'b0;
        {center_button, left_button, right_button, up_button, down_button} = B_N;
        #7;
        compare(0, rst_d, "reset_d");
        compare(1, rst_d, "reset_r");
        compare(2, ob(8'h00, 8'h00, 8'h00, 2'b01, 2'b00, 1'b0), "reset_u");
        @(negedge clk_core);
        rst_n = 1'b1;

        // EDIT-mode table on the count-down instance, ending with preset 00:00.03
        add(B_D, ob(8'h05, 8'h59, 8'h00, 2'b01, 2'b00, 1'b0), "sec_dec_wrap");
        add(B_U, ob(8'h05, 8'h00, 8'h00, 2'b01, 2'b00, 1'b0), "sec_inc_wrap");
        add(B_L, ob(8'h05, 8'h00, 8'h00, 2'b10, 2'b00, 1'b0), "left1");
        add(B_L, ob(8'h05, 8'h00, 8'h00, 2'b10, 2'b00, 1'b0), "left_sat1");
        add(B_L, ob(8'h05, 8'h00, 8'h00, 2'b10, 2'b00, 1'b0), "left_sat2");
        for (int i = 4; i >= 0; i--)
            add(B_D, ob(8'(i), 8'h00, 8'h00, 2'b10, 2'b00, 1'b0), "min_dec");
        add(B_D, ob(8'h99, 8'h00, 8'h00, 2'b10, 2'b00, 1'b0), "min_dec_wrap");
        add(B_U, ob(8'h00, 8'h00, 8'h00, 2'b10, 2'b00, 1'b0), "min_inc_wrap");
        add(B_L | B_R, ob(8'h00, 8'h00, 8'h00, 2'b10, 2'b00, 1'b0), "two_hot_lr");
        add(B_U | B_D, ob(8'h00, 8'h00, 8'h00, 2'b10, 2'b00, 1'b0), "two_hot_ud");
        add(B_R, ob(8'h00, 8'h00, 8'h00, 2'b01, 2'b00, 1'b0), "right1");
        add(B_R, ob(8'h00, 8'h00, 8'h00, 2'b00, 2'b00, 1'b0), "right2");
        add(B_R, ob(8'h00, 8'h00, 8'h00, 2'b00, 2'b00, 1'b0), "right_sat");
        add(B_D, ob(8'h00, 8'h00, 8'h99, 2'b00, 2'b00, 1'b0), "cs_dec_wrap");
        add(B_U, ob(8'h00, 8'h00, 8'h00, 2'b00, 2'b00, 1'b0), "cs_inc_wrap");
        add(B_C, ob(8'h00, 8'h00, 8'h00, 2'b00, 2'b00, 1'b0), "zero_start_blocked");
        add(B_U, ob(8'h00, 8'h00, 8'h01, 2'b00, 2'b00, 1'b0), "cs_inc1");
        add(B_U, ob(8'h00, 8'h00, 8'h02, 2'b00, 2'b00, 1'b0), "cs_inc2");
        add(B_U, ob(8'h00, 8'h00, 8'h03, 2'b00, 2'b00, 1'b0), "cs_inc3");
        foreach (tbl[i])
            step(tbl[i].btn, 0, tbl[i].v, tbl[i].name);

        // Count down 00:00.03 to DONE, one tick every 4 cycles
        step(B_C, 0, ob(8'h00, 8'h00, 8'h03, 2'b11, 2'b01, 1'b0), "start_down");
        for (int k = 1; k <= 12; k++)
            step(B_N, 0, ob(8'h00, 8'h00, 8'(3 - k / 4), 2'b11,
                            (k == 12) ? 2'b11 : 2'b01, (k == 12)), "count_down");
        for (int k = 0; k < 3; k++)
            step(B_N, 0, ob(8'h00, 8'h00, 8'h00, 2'b11, 2'b11, 1'b1), "done_hold");
        step(B_L, 0, ob(8'h00, 8'h00, 8'h00, 2'b11, 2'b11, 1'b1), "done_ignore_left");
        step(B_C, 0, ob(8'h00, 8'h00, 8'h03, 2'b01, 2'b00, 1'b0), "done_ack");

        // Pause / resume / abort with preset 00:01.00
        do_reset();
        step(B_L, 0, ob(8'h05, 8'h00, 8'h00, 2'b10, 2'b00, 1'b0), "p_left");
        for (int i = 4; i >= 0; i--)
            step(B_D, 0, ob(8'(i), 8'h00, 8'h00, 2'b10, 2'b00, 1'b0), "p_min");
        step(B_R, 0, ob(8'h00, 8'h00, 8'h00, 2'b01, 2'b00, 1'b0), "p_right");
        step(B_U, 0, ob(8'h00, 8'h01, 8'h00, 2'b01, 2'b00, 1'b0), "p_sec");
        step(B_C, 0, ob(8'h00, 8'h01, 8'h00, 2'b11, 2'b01, 1'b0), "p_start");
        for (int k = 1; k <= 5; k++)
            step(B_N, 0, (k < 4) ? ob(8'h00, 8'h01, 8'h00, 2'b11, 2'b01, 1'b0)
                                 : ob(8'h00, 8'h00, 8'h99, 2'b11, 2'b01, 1'b0), "p_run");
        step(B_C, 0, ob(8'h00, 8'h00, 8'h99, 2'b11, 2'b10, 1'b0), "pause");
        for (int k = 0; k < 20; k++)
            step(B_N, 0, ob(8'h00, 8'h00, 8'h99, 2'b11, 2'b10, 1'b0), "pause_hold");
        step(B_U, 0, ob(8'h00, 8'h00, 8'h99, 2'b11, 2'b10, 1'b0), "pause_ignore_up");
        step(B_C, 0, ob(8'h00, 8'h00, 8'h99, 2'b11, 2'b01, 1'b0), "resume");
        for (int k = 1; k <= 3; k++)
            step(B_N, 0, (k < 3) ? ob(8'h00, 8'h00, 8'h99, 2'b11, 2'b01, 1'b0)
                                 : ob(8'h00, 8'h00, 8'h98, 2'b11, 2'b01, 1'b0), "resume_presc");
        step(B_C, 0, ob(8'h00, 8'h00, 8'h98, 2'b11, 2'b10, 1'b0), "pause2");
        step(B_R, 0, ob(8'h00, 8'h01, 8'h00, 2'b01, 2'b00, 1'b0), "abort");

        // Auto-reload with preset 00:00.02
        do_reset();
        step(B_L, 1, ob(8'h05, 8'h00, 8'h00, 2'b10, 2'b00, 1'b0), "ar_left");
        for (int i = 4; i >= 0; i--)
            step(B_D, 1, ob(8'(i), 8'h00, 8'h00, 2'b10, 2'b00, 1'b0), "ar_min");
        step(B_R, 1, ob(8'h00, 8'h00, 8'h00, 2'b01, 2'b00, 1'b0), "ar_right1");
        step(B_R, 1, ob(8'h00, 8'h00, 8'h00, 2'b00, 2'b00, 1'b0), "ar_right2");
        step(B_U, 1, ob(8'h00, 8'h00, 8'h01, 2'b00, 2'b00, 1'b0), "ar_cs1");
        step(B_U, 1, ob(8'h00, 8'h00, 8'h02, 2'b00, 2'b00, 1'b0), "ar_cs2");
        step(B_C, 1, ob(8'h00, 8'h00, 8'h02, 2'b11, 2'b01, 1'b0), "ar_start");
        for (int k = 1; k <= 24; k++)
            step(B_N, 1, ob(8'h00, 8'h00, (((k / 4) % 2) == 0) ? 8'h02 : 8'h01,
                            2'b11, 2'b01, ((k % 8) == 0)), "ar_run");

        // Asynchronous reset between clock edges while running / done
        #2;
        rst_n = 1'b0;
        #1;
        compare(1, rst_d, "async_rst_r");
        compare(0, rst_d, "async_rst_d");
        @(negedge clk_core);
        rst_n = 1'b1;

        // Count-up to 00:59.99 with MIN_MAX=00
        step(B_C, 2, ob(8'h00, 8'h00, 8'h00, 2'b11, 2'b01, 1'b0), "up_start");
        idle(3995);
        step(B_N, 2, ob(8'h00, 8'h09, 8'h99, 2'b11, 2'b01, 1'b0), "up_0999");
        idle(3);
        step(B_N, 2, ob(8'h00, 8'h10, 8'h00, 2'b11, 2'b01, 1'b0), "up_carry");
        idle(19994);
        step(B_N, 2, ob(8'h00, 8'h59, 8'h98, 2'b11, 2'b01, 1'b0), "up_5998");
        step(B_N, 2, ob(8'h00, 8'h59, 8'h99, 2'b11, 2'b11, 1'b1), "up_done");
        step(B_C, 2, ob(8'h00, 8'h00, 8'h00, 2'b01, 2'b00, 1'b0), "up_ack");

        idle(2);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: left=%0d want=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
